// File: rtl/debug_frame_scheduler.sv
// Round-robin arbiter and framed serializer sharing one debug output wire
// between the key loader, message loader and ciphertext engine.
module debug_frame_scheduler #(
    parameter int unsigned PAYLOAD_W  = 7,
    parameter logic [3:0]  START_SEQ  = 4'b1111,
    parameter logic [3:0]  END_SEQ    = 4'b1001,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [2:0]           req_valid,
    input  logic [PAYLOAD_W-1:0] req_data0,
    input  logic [PAYLOAD_W-1:0] req_data1,
    input  logic [PAYLOAD_W-1:0] req_data2,
    output logic [2:0]           req_ready,
    output logic                 data_out,
    output logic                 data_flag,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    localparam int unsigned FRAME_W = 4 + 2 + PAYLOAD_W + 4;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef struct packed {
        logic [3:0]           start_seq;
        logic [1:0]           id;
        logic [PAYLOAD_W-1:0] payload;
        logic [3:0]           end_seq;
    } frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [1:0]           last_grant_q, last_grant_d;
    logic [2:0]           req_ready_d;
    logic                 data_out_d, data_flag_d, busy_d;
    logic [1:0]           grant_id_d;

    logic [3:0]           req_vec;
    logic [1:0]           cand0, cand1, cand2;
    logic                 win_valid;
    logic [1:0]           win_id;
    logic [PAYLOAD_W-1:0] win_payload;
    frame_t               frame_c;
    logic [FRAME_W-1:0]   frame_bits;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    // Rotating priority starting just after the last grant, plus frame assembly
    always_comb begin
        req_vec   = {1'b0, req_valid};
        cand0     = next_id(last_grant_q);
        cand1     = next_id(cand0);
        cand2     = next_id(cand1);
        win_valid = |req_valid;
        win_id    = cand2;
        if (req_vec[cand0]) begin
            win_id = cand0;
        end else if (req_vec[cand1]) begin
            win_id = cand1;
        end
        case (win_id)
            2'd0:    win_payload = req_data0;
            2'd1:    win_payload = req_data1;
            default: win_payload = req_data2;
        endcase
        frame_c.start_seq = START_SEQ;
        frame_c.id        = win_id;
        frame_c.payload   = win_payload;
        frame_c.end_seq   = END_SEQ;
        frame_bits        = frame_c;
    end

    // Next-state and registered-output logic; ena low forces a clean IDLE
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id;
        req_ready_d  = 3'b000;
        data_out_d   = 1'b0;
        data_flag_d  = 1'b0;
        busy_d       = 1'b0;

        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_valid) begin
                        req_ready_d  = 3'b001 << win_id;
                        shift_d      = frame_bits;
                        data_out_d   = frame_bits[FRAME_W-1];
                        data_flag_d  = 1'b1;
                        busy_d       = 1'b1;
                        grant_id_d   = win_id;
                        last_grant_d = win_id;
                        bit_cnt_d    = CNT_W'(FRAME_W - 1);
                        state_d      = SHIFT;
                    end
                end
                SHIFT: begin
                    busy_d = 1'b1;
                    if (bit_cnt_q == '0) begin
                        gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                        state_d   = GAP;
                    end else begin
                        shift_d     = shift_q << 1;
                        data_out_d  = shift_q[FRAME_W-2];
                        data_flag_d = 1'b1;
                        bit_cnt_d   = bit_cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                        busy_d    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 2'd2;
            req_ready    <= 3'b000;
            data_out     <= 1'b0;
            data_flag    <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= 2'd0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            req_ready    <= req_ready_d;
            data_out     <= data_out_d;
            data_flag    <= data_flag_d;
            busy         <= busy_d;
            grant_id     <= grant_id_d;
        end
    end

endmodule

// File: tb/tb_debug_frame_scheduler.sv
// Scoreboard bench for debug_frame_scheduler: expected frames are queued when
// requests are driven and compared against frames captured from the wire.
module tb_debug_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] req_valid;
    logic [6:0] req_data0, req_data1, req_data2;
    logic [2:0] req_ready;
    logic       data_out, data_flag, busy;
    logic [1:0] grant_id;

    typedef struct packed {
        logic [1:0]  id;
        logic [16:0] frame;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    debug_frame_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_ready (req_ready),
        .data_out  (data_out),
        .data_flag (data_flag),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    function automatic logic [16:0] mk(input logic [1:0] id, input logic [6:0] p);
        return {4'b1111, id, p, 4'b1001};
    endfunction

    task automatic push_exp(input logic [1:0] id, input logic [6:0] p);
        exp_t e;
        e.id    = id;
        e.frame = mk(id, p);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ena       = 1'b1;
        req_valid = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Captures one frame off the wire; returns at the first negedge with data_flag low
    task automatic recv_frame(input bit drop, input bit scramble,
                              output logic [16:0] f, output int nbits, output int waited,
                              output logic [2:0] rdy, output int rdy_n,
                              output logic [1:0] gid, output logic bsy, output bit tmo);
        f = '0; nbits = 0; waited = 0; rdy = '0; rdy_n = 0; gid = '0; bsy = 1'b0; tmo = 1'b0;
        while (data_flag !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (data_flag !== 1'b1) begin
            tmo = 1'b1;
            return;
        end
        rdy = req_ready;
        gid = grant_id;
        bsy = busy;
        if (drop) req_valid = req_valid & ~req_ready;
        while (data_flag === 1'b1 && nbits < 40) begin
            f = {f[15:0], data_out};
            nbits++;
            if (req_ready !== 3'b000) rdy_n++;
            if (scramble) begin
                req_data0 = 7'($urandom);
                req_data1 = 7'($urandom);
                req_data2 = 7'($urandom);
            end
            @(negedge clk);
        end
    endtask

    logic [16:0] f;
    int          nbits, waited, rdy_n;
    logic [2:0]  rdy;
    logic [1:0]  gid;
    logic        bsy;
    bit          tmo;
    exp_t        e;

    task automatic test_reset();
        do_reset();
        n_cmp++; if (data_out !== 1'b0)     begin n_err++; $display("FAIL reset_data_out got %b want 0", data_out); end
        n_cmp++; if (data_flag !== 1'b0)    begin n_err++; $display("FAIL reset_data_flag got %b want 0", data_flag); end
        n_cmp++; if (req_ready !== 3'b000)  begin n_err++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (grant_id !== 2'd0)     begin n_err++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    endtask

    task automatic test_single();
        do_reset();
        req_data0 = 7'h55;
        e.id = 2'd0;
        e.frame = 17'b11110010101011001;
        exp_q.push_back(e);
        req_valid = 3'b001;
        recv_frame(1'b1, 1'b0, f, nbits, waited, rdy, rdy_n, gid, bsy, tmo);
        e = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0)      begin n_err++; $display("FAIL single_timeout got %b want 0", tmo); end
        n_cmp++; if (f !== e.frame)     begin n_err++; $display("FAIL single_frame got %b want %b", f, e.frame); end
        n_cmp++; if (nbits != 17)       begin n_err++; $display("FAIL single_flag_len got %0d want 17", nbits); end
        n_cmp++; if (rdy !== 3'b001)    begin n_err++; $display("FAIL single_ready got %b want 001", rdy); end
        n_cmp++; if (rdy_n != 1)        begin n_err++; $display("FAIL single_ready_cycles got %0d want 1", rdy_n); end
        n_cmp++; if (gid !== e.id)      begin n_err++; $display("FAIL single_grant_id got %0d want %0d", gid, e.id); end
        n_cmp++; if (bsy !== 1'b1)      begin n_err++; $display("FAIL single_busy_shift got %b want 1", bsy); end
        n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL single_gap1_busy got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || data_flag !== 1'b0) begin n_err++; $display("FAIL single_gap2 got busy=%b flag=%b want busy=1 flag=0", busy, data_flag); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || data_flag !== 1'b0) begin n_err++; $display("FAIL single_idle got busy=%b flag=%b want busy=0 flag=0", busy, data_flag); end
    endtask

    task automatic test_three();
        do_reset();
        req_data0 = 7'h01; req_data1 = 7'h02; req_data2 = 7'h03;
        push_exp(2'd0, 7'h01);
        push_exp(2'd1, 7'h02);
        push_exp(2'd2, 7'h03);
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin
            recv_frame(1'b1, 1'b0, f, nbits, waited, rdy, rdy_n, gid, bsy, tmo);
            e = exp_q.pop_front();
            n_cmp++; if (tmo !== 1'b0)   begin n_err++; $display("FAIL three_timeout[%0d] got %b want 0", i, tmo); end
            n_cmp++; if (gid !== e.id)   begin n_err++; $display("FAIL three_grant[%0d] got %0d want %0d", i, gid, e.id); end
            n_cmp++; if (f !== e.frame)  begin n_err++; $display("FAIL three_frame[%0d] got %b want %b", i, f, e.frame); end
            n_cmp++; if (rdy !== (3'b001 << e.id)) begin n_err++; $display("FAIL three_ready[%0d] got %b want %b", i, rdy, 3'b001 << e.id); end
            if (i > 0) begin
                n_cmp++; if (waited != 3) begin n_err++; $display("FAIL three_gap[%0d] got %0d want 3", i, waited); end
            end
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req_data0 = 7'h11; req_data1 = 7'h22;
        req_valid = 3'b011;
        for (int i = 0; i < 6; i++) begin
            push_exp(2'(i % 2), (i % 2 == 0) ? 7'h11 : 7'h22);
            recv_frame(1'b0, 1'b0, f, nbits, waited, rdy, rdy_n, gid, bsy, tmo);
            e = exp_q.pop_front();
            n_cmp++; if (tmo !== 1'b0)   begin n_err++; $display("FAIL fair_timeout[%0d] got %b want 0", i, tmo); end
            n_cmp++; if (gid !== e.id)   begin n_err++; $display("FAIL fair_grant[%0d] got %0d want %0d", i, gid, e.id); end
            n_cmp++; if (f !== e.frame)  begin n_err++; $display("FAIL fair_frame[%0d] got %b want %b", i, f, e.frame); end
            n_cmp++; if (rdy !== (3'b001 << e.id)) begin n_err++; $display("FAIL fair_ready[%0d] got %b want %b", i, rdy, 3'b001 << e.id); end
        end
        req_valid = 3'b000;
    endtask

    task automatic test_ena_abort();
        logic [16:0] fr;
        int w;
        do_reset();
        req_data0 = 7'h0A; req_data1 = 7'h0B;
        fr = mk(2'd0, 7'h0A);
        req_valid = 3'b011;
        w = 0;
        while (data_flag !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        n_cmp++; if (data_flag !== 1'b1) begin n_err++; $display("FAIL abort_start got flag=%b want 1", data_flag); end
        repeat (9) @(negedge clk);
        n_cmp++; if (data_out !== fr[7]) begin n_err++; $display("FAIL abort_payload_bit3 got %b want %b", data_out, fr[7]); end
        ena = 1'b0;
        @(negedge clk);
        n_cmp++; if (data_out !== 1'b0 || data_flag !== 1'b0 || busy !== 1'b0 || req_ready !== 3'b000) begin
            n_err++; $display("FAIL abort_outputs got out=%b flag=%b busy=%b ready=%b want all 0", data_out, data_flag, busy, req_ready);
        end
        ena = 1'b1;
        push_exp(2'd1, 7'h0B);
        recv_frame(1'b1, 1'b0, f, nbits, waited, rdy, rdy_n, gid, bsy, tmo);
        req_valid = 3'b000;
        e = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0)  begin n_err++; $display("FAIL abort_timeout got %b want 0", tmo); end
        n_cmp++; if (waited != 1)   begin n_err++; $display("FAIL abort_regrant_latency got %0d want 1", waited); end
        n_cmp++; if (gid !== e.id)  begin n_err++; $display("FAIL abort_next_grant got %0d want %0d", gid, e.id); end
        n_cmp++; if (f !== e.frame) begin n_err++; $display("FAIL abort_next_frame got %b want %b", f, e.frame); end
    endtask

    task automatic test_reset_mid();
        logic [16:0] fr;
        int w;
        do_reset();
        req_data0 = 7'h73;
        fr = mk(2'd0, 7'h73);
        req_valid = 3'b001;
        w = 0;
        while (data_flag !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        repeat (6) @(negedge clk);
        n_cmp++; if (data_out !== fr[10] || data_flag !== 1'b1) begin n_err++; $display("FAIL rstmid_bit10 got out=%b flag=%b want out=%b flag=1", data_out, data_flag, fr[10]); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (data_out !== 1'b0 || data_flag !== 1'b0 || busy !== 1'b0 || req_ready !== 3'b000 || grant_id !== 2'd0) begin
            n_err++; $display("FAIL rstmid_outputs got out=%b flag=%b busy=%b ready=%b gid=%0d want all 0", data_out, data_flag, busy, req_ready, grant_id);
        end
        rst = 1'b0;
        req_data0 = 7'h41; req_data1 = 7'h42; req_data2 = 7'h43;
        req_valid = 3'b111;
        push_exp(2'd0, 7'h41);
        recv_frame(1'b1, 1'b0, f, nbits, waited, rdy, rdy_n, gid, bsy, tmo);
        req_valid = 3'b000;
        e = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0)  begin n_err++; $display("FAIL rstmid_timeout got %b want 0", tmo); end
        n_cmp++; if (gid !== e.id)  begin n_err++; $display("FAIL rstmid_first_grant got %0d want %0d", gid, e.id); end
        n_cmp++; if (f !== e.frame) begin n_err++; $display("FAIL rstmid_frame got %b want %b", f, e.frame); end
    endtask

    task automatic test_stability_drop();
        int flag_n, rdy_seen;
        do_reset();
        req_data1 = 7'h5A;
        push_exp(2'd1, 7'h5A);
        req_valid = 3'b010;
        recv_frame(1'b1, 1'b1, f, nbits, waited, rdy, rdy_n, gid, bsy, tmo);
        e = exp_q.pop_front();
        n_cmp++; if (tmo !== 1'b0)  begin n_err++; $display("FAIL stable_timeout got %b want 0", tmo); end
        n_cmp++; if (f !== e.frame) begin n_err++; $display("FAIL stable_frame got %b want %b", f, e.frame); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_in_gap got busy=%b want 1", busy); end
        req_data2 = 7'h7F;
        req_valid = 3'b100;
        @(negedge clk);
        req_valid = 3'b000;
        flag_n = 0; rdy_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (data_flag !== 1'b0) flag_n++;
            if (req_ready !== 3'b000) rdy_seen++;
        end
        n_cmp++; if (flag_n != 0)   begin n_err++; $display("FAIL drop_frame got %0d flag cycles want 0", flag_n); end
        n_cmp++; if (rdy_seen != 0) begin n_err++; $display("FAIL drop_ready got %0d ready cycles want 0", rdy_seen); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; req_valid = 3'b000;
        req_data0 = '0; req_data1 = '0; req_data2 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_three();
        test_fairness();
        test_ena_abort();
        test_reset_mid();
        test_stability_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
